// File: rtl/uart_tx_frame.sv
// UART transmitter: AXI-Stream words through a small FIFO, framed as start/5..DATA_WIDTH data/parity/1-2 stop or a line break.
// txd falls one cycle after a word lands in an idle, empty block; s_axis_tready drops only while the FIFO is full.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    output logic                             txd,
    output logic                             busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    input  logic [15:0]                      prescale,
    input  logic [3:0]                       cfg_data_bits,
    input  logic [1:0]                       cfg_parity,
    input  logic                             cfg_stop2,
    input  logic                             cfg_break
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [3:0] MAX_BITS = 4'(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_BREAK_STOP
    } state_t;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  not_full, empty, push, pop;
    logic [DATA_WIDTH-1:0] head;

    state_t                state, state_n;
    logic [18:0]           timer, timer_n, reload, reload_n;
    logic [DATA_WIDTH-1:0] shift, shift_n;
    logic [3:0]            bit_cnt, bit_cnt_n;
    logic                  stop_cnt, stop_cnt_n;
    logic [1:0]            par_mode, par_mode_n;
    logic                  stop2, stop2_n;
    logic                  par_bit, par_bit_n;
    logic                  txd_n;

    logic [3:0]            nbits;
    logic [DATA_WIDTH-1:0] mask;
    logic [18:0]           cfg_reload;
    logic                  tick, launch, brk;

    assign not_full      = (count != FULL);
    assign empty         = (count == '0);
    assign push          = s_axis_tvalid && not_full;
    assign s_axis_tready = !rst && not_full;
    assign fifo_count    = count;
    assign busy          = (state != S_IDLE) || !empty;
    assign head          = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    // Frame settings sampled at the moment a word is popped (or a break starts).
    always_comb begin
        mask = '0;
        if (cfg_data_bits < 4'd5)          nbits = 4'd5;
        else if (cfg_data_bits > MAX_BITS) nbits = MAX_BITS;
        else                               nbits = cfg_data_bits;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            mask[i] = (4'(i) < nbits);
        end
    end

    // (P*8)-1 == {P-1, 3'b111}; a prescale of 0 behaves as 1.
    assign cfg_reload = {(prescale == 16'd0) ? 16'd0 : prescale - 16'd1, 3'b111};
    assign tick       = (timer == '0);

    always_comb begin
        state_n    = state;
        timer_n    = tick ? reload : timer - 19'd1;
        reload_n   = reload;
        shift_n    = shift;
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        par_mode_n = par_mode;
        stop2_n    = stop2;
        par_bit_n  = par_bit;
        pop        = 1'b0;
        launch     = 1'b0;
        brk        = 1'b0;
        txd_n      = 1'b1;

        case (state)
            S_IDLE: begin
                timer_n = '0;
                if (cfg_break)   brk    = 1'b1;
                else if (!empty) launch = 1'b1;
            end
            S_START: begin
                if (tick) state_n = S_DATA;
            end
            S_DATA: begin
                if (tick) begin
                    shift_n = shift >> 1;
                    if (bit_cnt == 4'd0) begin
                        state_n    = (par_mode != 2'b00) ? S_PARITY : S_STOP;
                        stop_cnt_n = stop2;
                    end else begin
                        bit_cnt_n = bit_cnt - 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_n    = S_STOP;
                    stop_cnt_n = stop2;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (stop_cnt)                stop_cnt_n = 1'b0;
                    else if (cfg_break)          brk        = 1'b1;
                    else if (!empty)             launch     = 1'b1;
                    else                         state_n    = S_IDLE;
                end
            end
            S_BREAK: begin
                if (tick && !cfg_break) begin
                    state_n    = S_BREAK_STOP;
                    stop_cnt_n = stop2;
                end
            end
            S_BREAK_STOP: begin
                if (tick) begin
                    if (stop_cnt) stop_cnt_n = 1'b0;
                    else          state_n    = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (launch) begin
            pop        = 1'b1;
            state_n    = S_START;
            timer_n    = cfg_reload;
            reload_n   = cfg_reload;
            shift_n    = head;
            bit_cnt_n  = nbits - 4'd1;
            par_mode_n = cfg_parity;
            stop2_n    = cfg_stop2;
            par_bit_n  = ^(head & mask);
        end
        if (brk) begin
            state_n  = S_BREAK;
            timer_n  = cfg_reload;
            reload_n = cfg_reload;
            stop2_n  = cfg_stop2;
        end

        // txd is registered, so it is driven from the state being entered.
        case (state_n)
            S_START, S_BREAK: txd_n = 1'b0;
            S_DATA:           txd_n = shift_n[0];
            S_PARITY: begin
                case (par_mode_n)
                    2'b01:   txd_n = par_bit_n;
                    2'b10:   txd_n = !par_bit_n;
                    default: txd_n = 1'b0;
                endcase
            end
            default:          txd_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            timer    <= '0;
            reload   <= '0;
            shift    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_mode <= '0;
            stop2    <= 1'b0;
            par_bit  <= 1'b0;
            txd      <= 1'b1;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            reload   <= reload_n;
            shift    <= shift_n;
            bit_cnt  <= bit_cnt_n;
            stop_cnt <= stop_cnt_n;
            par_mode <= par_mode_n;
            stop2    <= stop2_n;
            par_bit  <= par_bit_n;
            txd      <= txd_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: a table of single-frame vectors, then FIFO-full,
// break and mid-frame reset sequences, all checked cycle by cycle against hand-derived frames.
module tb_uart_tx_frame;
    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       txd;
    logic       busy;
    logic [2:0] fifo_count;
    logic [15:0] prescale;
    logic [3:0] cfg_bits;
    logic [1:0] cfg_parity;
    logic       cfg_stop2;
    logic       cfg_break;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    uart_tx_frame #(.DATA_WIDTH(9), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
        .txd(txd), .busy(busy), .fifo_count(fifo_count),
        .prescale(prescale), .cfg_data_bits(cfg_bits), .cfg_parity(cfg_parity),
        .cfg_stop2(cfg_stop2), .cfg_break(cfg_break)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [8:0]  data;
        logic [3:0]  bits;
        logic [1:0]  par;
        logic        stop2;
        logic [15:0] pre;
        int          nb;       // effective data bits
        bit          pe;       // parity bit present
        bit          pv;       // expected parity bit
        int          bitlen;   // cycles per bit
        int          len;      // frame length in cycles
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [8:0] d, input int nb, input bit pe,
                                       input bit pv, input int b);
        if (b == 0) return 1'b0;
        if (b <= nb) return d[b-1];
        if (pe && b == nb + 1) return pv;
        return 1'b1;
    endfunction

    task automatic set_cfg(input logic [3:0] bits, input logic [1:0] par, input logic s2,
                           input logic [15:0] pre);
        cfg_bits = bits; cfg_parity = par; cfg_stop2 = s2; prescale = pre;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_frame(input logic [8:0] data, input int nb, input bit pe, input bit pv,
                               input int bitlen, input int len, input string tag);
        int bad = 0;
        tdata = data;
        tvalid = 1'b1;
        check({tag, " tready"}, int'(tready), 1);
        @(posedge clk); #1;
        tvalid = 1'b0;
        check({tag, " count"}, int'(fifo_count), 1);
        check({tag, " pre-start txd"}, int'(txd), 1);
        for (int k = 1; k <= len; k++) begin
            @(posedge clk); #1;
            if (txd !== frame_bit(data, nb, pe, pv, (k - 1) / bitlen)) bad++;
            if (k % bitlen == 0) begin
                check($sformatf("%s bit%0d bad cycles", tag, (k - 1) / bitlen), bad, 0);
                bad = 0;
            end
            if (k == len) check({tag, " busy last"}, int'(busy), 1);
        end
        @(posedge clk); #1;
        check({tag, " busy after"}, int'(busy), 0);
        check({tag, " idle txd"}, int'(txd), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [8:0] words[5];
        int idx, t0, bad;
        bit rdy, first, last, e;

        vecs[0] = '{9'h0A5, 4'd8,  2'b00, 1'b0, 16'd1, 8, 1'b0, 1'b0, 8,  80};
        vecs[1] = '{9'h041, 4'd7,  2'b01, 1'b1, 16'd2, 7, 1'b1, 1'b0, 16, 176};
        vecs[2] = '{9'h041, 4'd7,  2'b10, 1'b1, 16'd2, 7, 1'b1, 1'b1, 16, 176};
        vecs[3] = '{9'h1FF, 4'd9,  2'b10, 1'b0, 16'd1, 9, 1'b1, 1'b0, 8,  96};
        vecs[4] = '{9'h01F, 4'd3,  2'b00, 1'b0, 16'd0, 5, 1'b0, 1'b0, 8,  56};
        vecs[5] = '{9'h0FF, 4'd8,  2'b11, 1'b0, 16'd1, 8, 1'b1, 1'b0, 8,  88};
        vecs[6] = '{9'h155, 4'd15, 2'b01, 1'b0, 16'd1, 9, 1'b1, 1'b1, 8,  96};
        vecs[7] = '{9'h1C3, 4'd6,  2'b01, 1'b0, 16'd1, 6, 1'b1, 1'b0, 8,  72};
        words = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055};

        rst = 1'b1; tdata = '0; tvalid = 1'b0; cfg_break = 1'b0;
        set_cfg(4'd8, 2'b00, 1'b0, 16'd1);
        repeat (3) @(posedge clk);
        #1;
        check("reset txd", int'(txd), 1);
        check("reset busy", int'(busy), 0);
        check("reset count", int'(fifo_count), 0);
        check("reset tready", int'(tready), 0);
        @(negedge clk); rst = 1'b0; #1;
        check("release tready", int'(tready), 1);

        for (int i = 0; i < 8; i++) begin
            set_cfg(vecs[i].bits, vecs[i].par, vecs[i].stop2, vecs[i].pre);
            check_frame(vecs[i].data, vecs[i].nb, vecs[i].pe, vecs[i].pv,
                        vecs[i].bitlen, vecs[i].len, $sformatf("vec%0d", i));
        end

        // FIFO full with tvalid held high, then back-to-back drain at P=100.
        set_cfg(4'd8, 2'b00, 1'b0, 16'd100);
        t0 = -1; idx = 0; tdata = words[0]; tvalid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); rdy = tready;
            @(posedge clk); #1;
            if (rdy) begin
                idx++;
                tdata = (idx < 5) ? words[idx] : 9'h000;
            end
            if (t0 < 0 && txd == 1'b0) t0 = cyc;
        end
        tvalid = 1'b0;
        check("full accepted", idx, 5);
        check("full tready", int'(tready), 0);
        check("full count", int'(fifo_count), 4);
        check("full start seen", int'(t0 >= 0), 1);
        if (t0 >= 0) begin
            for (int j = 0; j < 50; j++) begin
                e = frame_bit(words[j / 10], 8, 1'b0, 1'b0, j % 10);
                wait_cyc(t0 + j * 800);
                first = txd;
                if (j == 10) begin
                    check("full tready after pop", int'(tready), 1);
                    check("full count after pop", int'(fifo_count), 3);
                end
                wait_cyc(t0 + j * 800 + 799);
                last = txd;
                if (j == 9) check("full tready before pop", int'(tready), 0);
                check($sformatf("full stream bit%0d", j), int'({first, last}), int'({e, e}));
            end
            wait_cyc(t0 + 40000);
            check("full busy after drain", int'(busy), 0);
        end
        @(posedge clk); #1;

        // Break requested mid-frame, held for three bit times; a word queued during it follows.
        set_cfg(4'd8, 2'b00, 1'b0, 16'd1);
        tdata = 9'h05A; tvalid = 1'b1;
        @(posedge clk); #1;
        tvalid = 1'b0;
        bad = 0;
        for (int k = 1; k <= 194; k++) begin
            @(posedge clk); #1;
            if (k <= 80)       e = frame_bit(9'h05A, 8, 1'b0, 1'b0, (k - 1) / 8);
            else if (k <= 104) e = 1'b0;
            else if (k <= 113) e = 1'b1;
            else if (k <= 193) e = frame_bit(9'h0C3, 8, 1'b0, 1'b0, (k - 114) / 8);
            else               e = 1'b1;
            if (txd !== e) bad++;
            case (k)
                80:  begin check("brk frame1", bad, 0); bad = 0; end
                104: begin check("brk low", bad, 0); bad = 0; end
                112: begin check("brk stop", bad, 0); bad = 0; end
                113: begin check("brk idle gap", bad, 0); bad = 0; end
                193: begin check("brk frame2", bad, 0); bad = 0; end
                194: begin
                    check("brk final txd", bad, 0);
                    check("brk busy after", int'(busy), 0);
                end
                default: ;
            endcase
            if (k == 20) cfg_break = 1'b1;
            if (k == 90) begin tdata = 9'h0C3; tvalid = 1'b1; end
            if (k == 91) begin
                tvalid = 1'b0;
                check("brk queued count", int'(fifo_count), 1);
            end
            if (k == 104) cfg_break = 1'b0;
        end

        // Reset in the middle of a data bit with two words queued.
        tdata = 9'h000; tvalid = 1'b1;
        @(posedge clk); #1;
        tdata = 9'h011;
        @(posedge clk); #1;
        tdata = 9'h022;
        @(posedge clk); #1;
        tvalid = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        check("rst pre txd", int'(txd), 0);
        check("rst pre count", int'(fifo_count), 2);
        #2 rst = 1'b1;
        #1;
        check("rst mid txd", int'(txd), 1);
        check("rst mid count", int'(fifo_count), 0);
        check("rst mid busy", int'(busy), 0);
        check("rst mid tready", int'(tready), 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        check("rst release tready", int'(tready), 1);
        check_frame(9'h096, 8, 1'b0, 1'b0, 8, 80, "post-rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
